// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage and the decode logic it feeds:
// instruction field positions, special opcodes, fetch FSM states and the
// IF/ID pipeline register layout.
package cpu_pkg;

    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_STOP = 4'b1101;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 4'b1111;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int IMM_BIT = 27;

    // Widths carried by the IF/ID record; the fetch stage's default
    // parameters match these.
    localparam int CPU_ADDR_W  = 10;
    localparam int CPU_INSTR_W = 32;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic                   valid;
        logic [CPU_INSTR_W-1:0] instr;
        logic [CPU_ADDR_W-1:0]  pc;
    } if_id_t;

    // Opcode field of an instruction word.
    function automatic logic [OPCODE_W-1:0] get_opcode(input logic [CPU_INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer that parks an instruction-memory response which
// arrives while decode is stalled. A held entry is never overwritten; clear
// takes priority over capture.
module fetch_skid_buffer
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = CPU_ADDR_W,
    parameter int INSTR_W = CPU_INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               capture_i,
    input  logic [INSTR_W-1:0] data_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic               clear_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] data_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;

    // Next-entry selection: clear empties, capture fills only an empty slot.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (capture_i && !valid_q) begin
            valid_d = 1'b1;
            data_d  = data_i;
            pc_d    = pc_i;
        end
    end

    // Entry storage with asynchronous clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. Issues one word read
// per cycle to a 1-cycle-latency instruction memory, parks a response that
// lands during a stall in a skid buffer, flushes on redirect and stops
// fetching once a STOP instruction enters IF/ID.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                INSTR_W  = CPU_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic                imem_rd_en,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [ADDR_W-1:0]   redirect_pc_i,
    output logic                if_valid_o,
    output logic [INSTR_W-1:0]  if_instr_o,
    output logic [ADDR_W-1:0]   if_pc_o,
    output logic [OPCODE_W-1:0] if_operation_o,
    output logic                if_imm_o,
    output logic                halted_o
);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    if_id_t             if_id_q, if_id_d;

    logic               issue;
    logic               skid_capture;
    logic               skid_clear;
    logic               skid_valid;
    logic [INSTR_W-1:0] skid_data;
    logic [ADDR_W-1:0]  skid_pc;

    fetch_skid_buffer #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture_i (skid_capture),
        .data_i    (imem_rdata),
        .pc_i      (inflight_pc_q),
        .clear_i   (skid_clear),
        .valid_o   (skid_valid),
        .data_o    (skid_data),
        .pc_o      (skid_pc)
    );

    // Memory request: only while running and neither stalled nor redirected.
    always_comb begin
        issue      = (state_q == RUN) && !stall_i && !redirect_i;
        imem_rd_en = issue && rst_n;
        imem_addr  = pc_q;
    end

    // Next PC, FSM state, in-flight tracking, IF/ID contents and skid control.
    always_comb begin
        pc_d          = pc_q;
        state_d       = state_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if_id_d       = if_id_q;
        skid_capture  = 1'b0;
        skid_clear    = 1'b0;

        if (redirect_i) begin
            // Wrong-path work is discarded: IF/ID, skid and in-flight read.
            pc_d       = redirect_pc_i;
            state_d    = RUN;
            if_id_d    = '0;
            skid_clear = 1'b1;
        end else if (stall_i) begin
            // IF/ID holds; a response landing now is parked unless halted.
            if (state_q == HALT) begin
                skid_clear = 1'b1;
            end else if (inflight_q) begin
                skid_capture = 1'b1;
            end
        end else begin
            if (state_q == HALT) begin
                if_id_d    = '0;
                skid_clear = 1'b1;
            end else begin
                if (skid_valid) begin
                    if_id_d.valid = 1'b1;
                    if_id_d.instr = CPU_INSTR_W'(skid_data);
                    if_id_d.pc    = CPU_ADDR_W'(skid_pc);
                    skid_clear    = 1'b1;
                end else if (inflight_q) begin
                    if_id_d.valid = 1'b1;
                    if_id_d.instr = CPU_INSTR_W'(imem_rdata);
                    if_id_d.pc    = CPU_ADDR_W'(inflight_pc_q);
                end else begin
                    if_id_d = '0;
                end
                if (if_id_d.valid && (get_opcode(if_id_d.instr) == OP_STOP)) begin
                    state_d = HALT;
                end
            end
            if (issue) begin
                pc_d          = pc_q + ADDR_W'(1);
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            if_id_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            if_id_q       <= if_id_d;
        end
    end

    // IF/ID outputs; an empty slot decodes as NOP with no immediate.
    always_comb begin
        if_valid_o     = if_id_q.valid;
        if_instr_o     = INSTR_W'(if_id_q.instr);
        if_pc_o        = ADDR_W'(if_id_q.pc);
        if_operation_o = if_id_q.valid ? get_opcode(if_id_q.instr) : OP_NOP;
        if_imm_o       = if_id_q.valid && if_id_q.instr[IMM_BIT];
        halted_o       = (state_q == HALT);
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus randomized stall and
// redirect traffic, all compared against a FIFO-based reference model of the
// fetch pipeline. A second instance covers a non-zero reset PC and PC wrap.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [9:0]  imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_rdata;
    logic        stall_i;
    logic        redirect_i;
    logic [9:0]  redirect_pc_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [9:0]  if_pc_o;
    logic [3:0]  if_operation_o;
    logic        if_imm_o;
    logic        halted_o;

    logic        rst2_n;
    logic [9:0]  imem_addr2;
    logic        imem_rd_en2;
    logic [31:0] imem_rdata2;
    logic        stall2;
    logic        redirect2;
    logic [9:0]  redirect_pc2;
    logic        if_valid2;
    logic [31:0] if_instr2;
    logic [9:0]  if_pc2;
    logic [3:0]  if_operation2;
    logic        if_imm2;
    logic        halted2;

    logic [31:0] mem [1024];

    int checks = 0;
    int errors = 0;

    // Reference model: requested words wait in a FIFO until IF/ID takes them.
    typedef struct {
        logic [9:0]  pc;
        logic [31:0] instr;
    } fetched_t;

    fetched_t    pend[$];
    logic [9:0]  m_pc;
    bit          m_halt;
    bit          m_valid;
    logic [9:0]  m_ifpc;
    logic [31:0] m_ifinstr;
    bit          cur_stall;
    bit          cur_redir;
    logic [9:0]  cur_rpc;

    fetch_stage #(.ADDR_W(10), .INSTR_W(32), .RESET_PC(10'h000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rd_en     (imem_rd_en),
        .imem_rdata     (imem_rdata),
        .stall_i        (stall_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .if_valid_o     (if_valid_o),
        .if_instr_o     (if_instr_o),
        .if_pc_o        (if_pc_o),
        .if_operation_o (if_operation_o),
        .if_imm_o       (if_imm_o),
        .halted_o       (halted_o)
    );

    fetch_stage #(.ADDR_W(10), .INSTR_W(32), .RESET_PC(10'h3FE)) dut2 (
        .clk            (clk),
        .rst_n          (rst2_n),
        .imem_addr      (imem_addr2),
        .imem_rd_en     (imem_rd_en2),
        .imem_rdata     (imem_rdata2),
        .stall_i        (stall2),
        .redirect_i     (redirect2),
        .redirect_pc_i  (redirect_pc2),
        .if_valid_o     (if_valid2),
        .if_instr_o     (if_instr2),
        .if_pc_o        (if_pc2),
        .if_operation_o (if_operation2),
        .if_imm_o       (if_imm2),
        .halted_o       (halted2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous instruction memories with one cycle of read latency.
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
        if (imem_rd_en2) imem_rdata2 <= {22'b0, imem_addr2};
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        pend.delete();
        m_pc      = 10'h000;
        m_halt    = 1'b0;
        m_valid   = 1'b0;
        m_ifpc    = 10'h000;
        m_ifinstr = 32'h0;
    endtask

    // Drive one cycle of inputs, then compare outputs mid-cycle with the model.
    task automatic applyStimulus(input bit s, input bit r, input logic [9:0] p);
        logic [31:0] instr;
        stall_i       = s;
        redirect_i    = r;
        redirect_pc_i = p;
        cur_stall     = s;
        cur_redir     = r;
        cur_rpc       = p;
        @(negedge clk);
        instr = m_ifinstr;
        checkOutput("rd_en", 32'(imem_rd_en), 32'(!m_halt && !s && !r));
        checkOutput("addr", 32'(imem_addr), 32'(m_pc));
        checkOutput("valid", 32'(if_valid_o), 32'(m_valid));
        checkOutput("halted", 32'(halted_o), 32'(m_halt));
        if (m_valid) begin
            checkOutput("if_pc", 32'(if_pc_o), 32'(m_ifpc));
            checkOutput("if_instr", if_instr_o, instr);
            checkOutput("if_op", 32'(if_operation_o), 32'(instr[31:28]));
            checkOutput("if_imm", 32'(if_imm_o), 32'(instr[27]));
        end else begin
            checkOutput("bubble_op", 32'(if_operation_o), 32'h0000_000F);
            checkOutput("bubble_imm", 32'(if_imm_o), 32'h0);
        end
    endtask

    // Advance the model across the clock edge, then let the DUT take it.
    task automatic clockEdge();
        fetched_t f;
        bit       req;
        logic [31:0] instr;
        req = !m_halt && !cur_stall && !cur_redir;
        if (cur_redir) begin
            pend.delete();
            m_valid = 1'b0;
            m_halt  = 1'b0;
            m_pc    = cur_rpc;
        end else if (cur_stall) begin
            if (m_halt) pend.delete();
        end else if (m_halt) begin
            m_valid = 1'b0;
            pend.delete();
        end else begin
            if (pend.size() > 0) begin
                f         = pend.pop_front();
                m_valid   = 1'b1;
                m_ifpc    = f.pc;
                m_ifinstr = f.instr;
            end else begin
                m_valid = 1'b0;
            end
            if (req) begin
                f.pc    = m_pc;
                f.instr = mem[m_pc];
                pend.push_back(f);
                m_pc = m_pc + 10'd1;
            end
            instr = m_ifinstr;
            if (m_valid && instr[31:28] == 4'b1101) begin
                m_halt = 1'b1;
                pend.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n         = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 10'h000;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(if_valid_o), 32'h0);
        checkOutput("rst_rd_en", 32'(imem_rd_en), 32'h0);
        checkOutput("rst_addr", 32'(imem_addr), 32'h0);
        checkOutput("rst_op", 32'(if_operation_o), 32'h0000_000F);
        checkOutput("rst_imm", 32'(if_imm_o), 32'h0);
        checkOutput("rst_halted", 32'(halted_o), 32'h0);
        checkOutput("rst_instr", if_instr_o, 32'h0);
        checkOutput("rst_pc", 32'(if_pc_o), 32'h0);
        rst_n = 1'b1;
        modelReset();
    endtask

    initial begin
        logic [9:0] e;
        rst_n        = 1'b0;
        rst2_n       = 1'b0;
        stall2       = 1'b0;
        redirect2    = 1'b0;
        redirect_pc2 = 10'h000;
        for (int i = 0; i < 1024; i++) mem[i] = {4'b0000, 28'(i)};

        // Straight-line fetch from reset.
        doReset();
        for (int c = 0; c < 7; c++) begin
            applyStimulus(1'b0, 1'b0, 10'h000);
            checkOutput("t1_addr", 32'(imem_addr), 32'(c));
            if (c >= 2) begin
                checkOutput("t1_pc", 32'(if_pc_o), 32'(c - 2));
                checkOutput("t1_op", 32'(if_operation_o), 32'h0);
            end
            clockEdge();
        end

        // Three-cycle stall while IF/ID holds pc 5; pc 6 goes to the skid.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 1'b0, 10'h000);
            checkOutput("t2_hold_pc", 32'(if_pc_o), 32'd5);
            checkOutput("t2_rd_en", 32'(imem_rd_en), 32'h0);
            clockEdge();
        end
        applyStimulus(1'b0, 1'b0, 10'h000);
        checkOutput("t2_rel_pc", 32'(if_pc_o), 32'd5);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 10'h000);
        checkOutput("t2_skid_pc", 32'(if_pc_o), 32'd6);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 10'h000);
        checkOutput("t2_next_pc", 32'(if_pc_o), 32'd7);
        clockEdge();

        // Stall to fill the skid, then redirect to 0x2A0 while still stalled.
        applyStimulus(1'b1, 1'b0, 10'h000);
        clockEdge();
        applyStimulus(1'b1, 1'b1, 10'h2A0);
        checkOutput("t3_rd_en", 32'(imem_rd_en), 32'h0);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 10'h000);
        checkOutput("t3_flush_valid", 32'(if_valid_o), 32'h0);
        checkOutput("t3_req_addr", 32'(imem_addr), 32'h2A0);
        checkOutput("t3_req_en", 32'(imem_rd_en), 32'h1);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 10'h000);
        checkOutput("t3_no_stale", 32'(if_valid_o), 32'h0);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 10'h000);
        checkOutput("t3_tgt_valid", 32'(if_valid_o), 32'h1);
        checkOutput("t3_tgt_pc", 32'(if_pc_o), 32'h2A0);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 10'h000);
        checkOutput("t3_tgt_next", 32'(if_pc_o), 32'h2A1);
        clockEdge();

        // STOP at address 4, reached by redirecting to 0.
        mem[4] = {4'b1101, 28'd4};
        applyStimulus(1'b0, 1'b1, 10'h000);
        clockEdge();
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b0, 1'b0, 10'h000);
            if (k == 7) begin
                checkOutput("t4_stop_pc", 32'(if_pc_o), 32'd4);
                checkOutput("t4_stop_op", 32'(if_operation_o), 32'h0000_000D);
                checkOutput("t4_stop_rd", 32'(imem_rd_en), 32'h0);
            end
            if (k >= 8) begin
                checkOutput("t4_halted", 32'(halted_o), 32'h1);
                checkOutput("t4_halt_valid", 32'(if_valid_o), 32'h0);
                checkOutput("t4_halt_op", 32'(if_operation_o), 32'h0000_000F);
                checkOutput("t4_halt_rd", 32'(imem_rd_en), 32'h0);
            end
            clockEdge();
        end

        // Leave HALT by redirecting to 0x010.
        applyStimulus(1'b0, 1'b1, 10'h010);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 10'h000);
        checkOutput("t5_unhalt", 32'(halted_o), 32'h0);
        checkOutput("t5_addr", 32'(imem_addr), 32'h010);
        checkOutput("t5_rd_en", 32'(imem_rd_en), 32'h1);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 10'h000);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 10'h000);
        checkOutput("t5_pc", 32'(if_pc_o), 32'h010);
        checkOutput("t5_valid", 32'(if_valid_o), 32'h1);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 10'h000);
        clockEdge();

        // Asynchronous reset in the middle of a stalled redirect cycle.
        applyStimulus(1'b1, 1'b1, 10'h123);
        checkOutput("t6_pre_valid", 32'(if_valid_o), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_valid", 32'(if_valid_o), 32'h0);
        checkOutput("t6_async_op", 32'(if_operation_o), 32'h0000_000F);
        checkOutput("t6_async_rd", 32'(imem_rd_en), 32'h0);
        checkOutput("t6_async_addr", 32'(imem_addr), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();

        // Randomized stall/redirect traffic over random program contents.
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int c = 0; c < 800; c++) begin
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                          10'($urandom_range(0, 1023)));
            clockEdge();
        end

        // Non-zero reset PC with wrap, on the second instance.
        rst_n  = 1'b0;
        rst2_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            e = 10'h3FE + 10'(c);
            checkOutput("w_addr", 32'(imem_addr2), 32'(e));
            checkOutput("w_rd_en", 32'(imem_rd_en2), 32'h1);
            if (c >= 2) begin
                e = 10'h3FE + 10'(c - 2);
                checkOutput("w_valid", 32'(if_valid2), 32'h1);
                checkOutput("w_pc", 32'(if_pc2), 32'(e));
                checkOutput("w_instr", if_instr2, {22'b0, e});
                checkOutput("w_op", 32'(if_operation2), 32'h0);
                checkOutput("w_imm", 32'(if_imm2), 32'h0);
            end
            @(posedge clk);
            #1;
        end
        #3;
        checkOutput("w_pre_valid", 32'(if_valid2), 32'h1);
        rst2_n = 1'b0;
        #1;
        checkOutput("w_async_valid", 32'(if_valid2), 32'h0);
        checkOutput("w_async_addr", 32'(imem_addr2), 32'h3FE);
        checkOutput("w_async_halted", 32'(halted2), 32'h0);
        checkOutput("w_async_op", 32'(if_operation2), 32'h0000_000F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
